// File: rtl/c7bifu_pkg.sv
// rtl/c7bifu_pkg.sv - shared c7bifu constants and helpers
package c7bifu_pkg;

    // Default PC width used across the instruction-fetch unit
    localparam int PC_W_DEF = 32;

    // Any of the execute-stage redirect sources empties the fetch pipeline
    function automatic logic ifu_flush(input logic except, input logic branch, input logic ertn);
        return except | branch | ertn;
    endfunction

endpackage

// File: rtl/c7bifu_dff.sv
// rtl/c7bifu_dff.sv - generic register cell with asynchronous clear
module c7bifu_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Plain state flop, cleared the moment reset rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_o <= '0;
        else       q_o <= d_i;
    end

endmodule

// File: rtl/c7bifu_ibuf_ptr.sv
// rtl/c7bifu_ibuf_ptr.sv - instruction buffer pointer and occupancy tracking
module c7bifu_ibuf_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_vld_i,
    input  logic          pop_rdy_i,
    input  logic          flush_i,
    output logic [AW-1:0] rptr_o,
    output logic [AW-1:0] wptr_o,
    output logic [CW-1:0] count_o,
    output logic          wr_en_o,
    output logic          ovf_set_o
);

    logic [AW-1:0] rptr_d, rptr_q;
    logic [AW-1:0] wptr_d, wptr_q;
    logic [CW-1:0] count_d, count_q;
    logic          pop;
    logic          full_all;

    // A pop frees a slot in the same cycle, so a push into a full buffer is legal alongside it
    always_comb begin
        full_all  = (count_q == CW'(DEPTH));
        pop       = (count_q != '0) & pop_rdy_i & ~flush_i;
        wr_en_o   = push_vld_i & ~flush_i & (~full_all | pop);
        ovf_set_o = push_vld_i & ~flush_i & full_all & ~pop;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            rptr_d  = rptr_q + AW'(pop);
            wptr_d  = wptr_q + AW'(wr_en_o);
            count_d = count_q + CW'(wr_en_o) - CW'(pop);
        end
    end

    c7bifu_dff #(.W(AW)) u_rptr  (.clk(clk), .reset(reset), .d_i(rptr_d),  .q_o(rptr_q));
    c7bifu_dff #(.W(AW)) u_wptr  (.clk(clk), .reset(reset), .d_i(wptr_d),  .q_o(wptr_q));
    c7bifu_dff #(.W(CW)) u_count (.clk(clk), .reset(reset), .d_i(count_d), .q_o(count_q));

    assign rptr_o  = rptr_q;
    assign wptr_o  = wptr_q;
    assign count_o = count_q;

endmodule

// File: rtl/c7bifu_ibuf.sv
// rtl/c7bifu_ibuf.sv - instruction buffer between fetch and decode
module c7bifu_ibuf
    import c7bifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            icu_data_vld,
    input  logic [31:0]     icu_ifu_data_ic2,
    input  logic [PC_W-1:0] fdp_ibuf_pc,
    input  logic            exu_ifu_except,
    input  logic            exu_ifu_branch,
    input  logic            exu_ifu_ertn,
    input  logic            exu_ifu_ready,
    output logic            ifu_exu_valid,
    output logic [31:0]     ifu_exu_inst,
    output logic [PC_W-1:0] ifu_exu_pc,
    output logic            ifu_exu_adef,
    output logic            ibuf_fcl_full,
    output logic            ibuf_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic          wr_en, ovf_set, flush;
    logic          ovf_d, ovf_q;

    logic [31:0]     inst_mem [DEPTH];
    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic            adef_mem [DEPTH];

    assign flush = ifu_flush(exu_ifu_except, exu_ifu_branch, exu_ifu_ertn);

    c7bifu_ibuf_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .push_vld_i (icu_data_vld),
        .pop_rdy_i  (exu_ifu_ready),
        .flush_i    (flush),
        .rptr_o     (rptr),
        .wptr_o     (wptr),
        .count_o    (count),
        .wr_en_o    (wr_en),
        .ovf_set_o  (ovf_set)
    );

    // Entry payload; misalignment is captured at write so the head never re-derives it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem[wptr] <= icu_ifu_data_ic2;
            pc_mem[wptr]   <= fdp_ibuf_pc;
            adef_mem[wptr] <= (fdp_ibuf_pc[1:0] != 2'b00);
        end
    end

    // Overflow stays set until reset so software can see that a fetch was lost
    assign ovf_d = ovf_q | ovf_set;
    c7bifu_dff #(.W(1)) u_ovf (.clk(clk), .reset(reset), .d_i(ovf_d), .q_o(ovf_q));

    // Full is raised one slot early to absorb the fetch already in flight
    assign ifu_exu_valid = (count != '0);
    assign ibuf_fcl_full = (count >= CW'(DEPTH - 1));
    assign ibuf_ovf      = ovf_q;
    assign ifu_exu_inst  = inst_mem[rptr];
    assign ifu_exu_pc    = pc_mem[rptr];
    assign ifu_exu_adef  = adef_mem[rptr];

endmodule

// File: tb/tb_c7bifu_ibuf.sv
// tb/tb_c7bifu_ibuf.sv - scoreboard bench for the instruction buffer
module tb_c7bifu_ibuf;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            icu_data_vld = 1'b0;
    logic [31:0]     icu_ifu_data_ic2 = '0;
    logic [PC_W-1:0] fdp_ibuf_pc = '0;
    logic            exu_ifu_except = 1'b0;
    logic            exu_ifu_branch = 1'b0;
    logic            exu_ifu_ertn = 1'b0;
    logic            exu_ifu_ready = 1'b0;
    logic            ifu_exu_valid;
    logic [31:0]     ifu_exu_inst;
    logic [PC_W-1:0] ifu_exu_pc;
    logic            ifu_exu_adef;
    logic            ibuf_fcl_full;
    logic            ibuf_ovf;

    c7bifu_ibuf #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .icu_data_vld     (icu_data_vld),
        .icu_ifu_data_ic2 (icu_ifu_data_ic2),
        .fdp_ibuf_pc      (fdp_ibuf_pc),
        .exu_ifu_except   (exu_ifu_except),
        .exu_ifu_branch   (exu_ifu_branch),
        .exu_ifu_ertn     (exu_ifu_ertn),
        .exu_ifu_ready    (exu_ifu_ready),
        .ifu_exu_valid    (ifu_exu_valid),
        .ifu_exu_inst     (ifu_exu_inst),
        .ifu_exu_pc       (ifu_exu_pc),
        .ifu_exu_adef     (ifu_exu_adef),
        .ibuf_fcl_full    (ibuf_fcl_full),
        .ibuf_ovf         (ibuf_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic            adef;
    } entry_t;

    entry_t mq[$];
    logic   m_ovf = 1'b0;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs with the reference queue, then advance the reference using the inputs the next edge will see
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            chk("valid", 64'(ifu_exu_valid), 64'(mq.size() != 0));
            chk("full", 64'(ibuf_fcl_full), 64'(mq.size() >= DEPTH - 1));
            chk("ovf", 64'(ibuf_ovf), 64'(m_ovf));
            if (ifu_exu_valid && mq.size() != 0) begin
                chk("head_inst", 64'(ifu_exu_inst), 64'(mq[0].inst));
                chk("head_pc", 64'(ifu_exu_pc), 64'(mq[0].pc));
                chk("head_adef", 64'(ifu_exu_adef), 64'(mq[0].adef));
            end
            if (exu_ifu_except || exu_ifu_branch || exu_ifu_ertn) begin
                mq.delete();
            end else begin
                bit pop, was_full;
                entry_t e;
                pop      = (mq.size() != 0) && exu_ifu_ready;
                was_full = (mq.size() == DEPTH);
                if (pop) void'(mq.pop_front());
                if (icu_data_vld) begin
                    if (!was_full || pop) begin
                        e.inst = icu_ifu_data_ic2;
                        e.pc   = fdp_ibuf_pc;
                        e.adef = (fdp_ibuf_pc % 4) != 0;
                        mq.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Apply one cycle of stimulus just after the rising edge
    task automatic cyc(input logic v, input logic [31:0] i, input logic [PC_W-1:0] p,
                       input logic r, input logic [2:0] fl);
        @(posedge clk);
        #1;
        icu_data_vld     = v;
        icu_ifu_data_ic2 = i;
        fdp_ibuf_pc      = p;
        exu_ifu_ready    = r;
        exu_ifu_except   = fl[0];
        exu_ifu_branch   = fl[1];
        exu_ifu_ertn     = fl[2];
    endtask

    task automatic idle(input logic r, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, '0, r, 3'b000);
    endtask

    // Reset is raised mid-cycle to confirm the outputs clear without waiting for an edge
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(ifu_exu_valid), 64'd0);
        chk("rst_full", 64'(ibuf_fcl_full), 64'd0);
        chk("rst_ovf", 64'(ibuf_ovf), 64'd0);
        icu_data_vld   = 1'b0;
        exu_ifu_ready  = 1'b0;
        exu_ifu_except = 1'b0;
        exu_ifu_branch = 1'b0;
        exu_ifu_ertn   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(ifu_exu_valid), 64'd0);
        chk("reset_ovf", 64'(ibuf_ovf), 64'd0);
        reset = 1'b0;

        // First word reaches the head one cycle after its push; then fill, overflow, drain
        cyc(1'b1, 32'h00100093, 32'h1C000000, 1'b0, 3'b000);
        cyc(1'b1, 32'h11111111, 32'h1C000004, 1'b0, 3'b000);
        cyc(1'b1, 32'h22222222, 32'h1C000008, 1'b0, 3'b000);
        cyc(1'b1, 32'h33333333, 32'h1C00000C, 1'b0, 3'b000);
        cyc(1'b1, 32'h44444444, 32'h1C000010, 1'b0, 3'b000);
        idle(1'b0, 2);
        idle(1'b1, 6);
        do_reset();

        // Branch together with a push leaves the buffer empty, then the next fetch is kept
        cyc(1'b1, 32'hA0000001, 32'h1C000100, 1'b0, 3'b000);
        cyc(1'b1, 32'hA0000002, 32'h1C000104, 1'b0, 3'b000);
        cyc(1'b1, 32'hA0000003, 32'h1C000108, 1'b1, 3'b010);
        cyc(1'b1, 32'hA0000004, 32'h1C00010C, 1'b0, 3'b000);
        cyc(1'b0, 32'h0, '0, 1'b0, 3'b001);
        cyc(1'b1, 32'hA0000005, 32'h1C000110, 1'b0, 3'b100);
        idle(1'b1, 3);

        // Full buffer streaming through push+pop across pointer wrap
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'hB0000000 + k, 32'h1C000200 + 4 * k, 1'b0, 3'b000);
        for (int k = 4; k < 11; k++) cyc(1'b1, 32'hB0000000 + k, 32'h1C000200 + 4 * k, 1'b1, 3'b000);
        idle(1'b1, 6);

        // Only the misaligned entry carries adef
        cyc(1'b1, 32'hC0000000, 32'h1C000000, 1'b0, 3'b000);
        cyc(1'b1, 32'hC0000001, 32'h1C000002, 1'b0, 3'b000);
        cyc(1'b1, 32'hC0000002, 32'h1C000004, 1'b0, 3'b000);
        idle(1'b1, 5);

        // Reset mid-operation with three entries queued
        cyc(1'b1, 32'hD0000000, 32'h1C000300, 1'b0, 3'b000);
        cyc(1'b1, 32'hD0000001, 32'h1C000304, 1'b0, 3'b000);
        cyc(1'b1, 32'hD0000002, 32'h1C000308, 1'b0, 3'b000);
        idle(1'b0, 1);
        do_reset();
        cyc(1'b1, 32'hD0000003, 32'h1C00030C, 1'b0, 3'b000);
        idle(1'b0, 2);
        idle(1'b1, 2);

        // Randomized traffic against the reference queue
        for (int k = 0; k < 400; k++) begin
            logic [2:0] fl;
            rv = $urandom;
            fl = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            cyc($urandom_range(0, 9) < 6, rv, {$urandom, 2'b00} | 32'($urandom_range(0, 7) == 0),
                $urandom_range(0, 1) == 1, fl);
        end
        idle(1'b1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
